// File: rtl/ahb_master.sv
// AHB-Lite single-transfer initiator: valid/ready command port in, pipelined NONSEQ transfers out.
// ERROR responses drop the address stage to IDLE and replay the held request afterwards.
//
// state     | meaning
// ST_RUN    | normal issue; new requests accepted whenever HREADY is high
// ST_REPLAY | ERROR cancelled the pending address phase; re-issue it at the next ready edge
module ahb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk_ahb,
    input  logic                  i_rstn_ahb,
    input  logic                  i_valid,
    input  logic                  i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_ready,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_err,
    input  logic                  i_hready,
    input  logic                  i_hresp,
    input  logic [DATA_WIDTH-1:0] i_hrdata,
    output logic [1:0]            o_htrans,
    output logic [ADDR_WIDTH-1:0] o_haddr,
    output logic                  o_hwrite,
    output logic [2:0]            o_hsize,
    output logic [2:0]            o_hburst,
    output logic [3:0]            o_hprot,
    output logic                  o_hmastlock,
    output logic [DATA_WIDTH-1:0] o_hwdata
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    state_t                  state_q,    state_d;
    logic                    nonseq_q,   nonseq_d;
    logic [ADDR_WIDTH-1:0]   haddr_q,    haddr_d;
    logic                    hwrite_q,   hwrite_d;
    logic [DATA_WIDTH-1:0]   wbuf_q,     wbuf_d;
    logic                    dp_valid_q, dp_valid_d;
    logic                    dp_write_q, dp_write_d;
    logic [DATA_WIDTH-1:0]   hwdata_q,   hwdata_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,  rd_data_d;
    logic                    err_q,      err_d;

    always_ff @(posedge i_clk_ahb) begin
        if (!i_rstn_ahb) begin
            state_q    <= ST_RUN;
            nonseq_q   <= 1'b0;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            wbuf_q     <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            hwdata_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            nonseq_q   <= nonseq_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            wbuf_q     <= wbuf_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            hwdata_q   <= hwdata_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nonseq_d   = nonseq_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        wbuf_d     = wbuf_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        hwdata_d   = hwdata_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        err_d      = 1'b0;

        if (i_hready) begin
            if (dp_valid_q) begin
                if (i_hresp) begin
                    err_d = 1'b1;
                end else if (!dp_write_q) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = i_hrdata;
                end
            end

            dp_valid_d = nonseq_q;
            dp_write_d = hwrite_q;
            if (nonseq_q && hwrite_q) begin
                hwdata_d = wbuf_q;
            end

            if (state_q == ST_REPLAY) begin
                nonseq_d = 1'b1;
                state_d  = ST_RUN;
            end else if (i_valid) begin
                nonseq_d = 1'b1;
                haddr_d  = i_addr;
                hwrite_d = i_rd0_wr1;
                wbuf_d   = i_wr_data;
            end else begin
                nonseq_d = 1'b0;
            end
        end else if (i_hresp && dp_valid_q && nonseq_q) begin
            // First ERROR cycle: withdraw the pending address phase, keep the request for replay.
            nonseq_d = 1'b0;
            state_d  = ST_REPLAY;
        end
    end

    assign o_ready     = i_hready & (state_q != ST_REPLAY);
    assign o_htrans    = nonseq_q ? 2'b10 : 2'b00;
    assign o_haddr     = haddr_q;
    assign o_hwrite    = hwrite_q;
    assign o_hwdata    = hwdata_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_err       = err_q;
    assign o_hsize     = 3'b010;
    assign o_hburst    = 3'b000;
    assign o_hprot     = 4'b0011;
    assign o_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: directed protocol scenarios plus randomized traffic against
// a slave model and an in-order completion scoreboard.
module tb_ahb_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic        rd0_wr1;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
    } req_t;

    ahb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk_ahb   (clk),
        .i_rstn_ahb  (rstn),
        .i_valid     (valid),
        .i_rd0_wr1   (rd0_wr1),
        .i_addr      (addr),
        .i_wr_data   (wr_data),
        .o_ready     (ready),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_err       (err),
        .i_hready    (hready),
        .i_hresp     (hresp),
        .i_hrdata    (hrdata),
        .o_htrans    (htrans),
        .o_haddr     (haddr),
        .o_hwrite    (hwrite),
        .o_hsize     (hsize),
        .o_hburst    (hburst),
        .o_hprot     (hprot),
        .o_hmastlock (hmastlock),
        .o_hwdata    (hwdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return a[7:4] == 4'hE;
    endfunction

    task automatic test_reset();
        rstn = 1'b0; valid = 1'b0; rd0_wr1 = 1'b0; addr = '0; wr_data = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        tick(); tick();
        n_total++; if (htrans !== 2'b00) $display("FAIL rst_htrans: got %b want 00", htrans); else n_pass++;
        n_total++; if (haddr !== 32'h0) $display("FAIL rst_haddr: got %h want 0", haddr); else n_pass++;
        n_total++; if (hwrite !== 1'b0) $display("FAIL rst_hwrite: got %b want 0", hwrite); else n_pass++;
        n_total++; if (hwdata !== 32'h0) $display("FAIL rst_hwdata: got %h want 0", hwdata); else n_pass++;
        n_total++; if ({rd_valid, err} !== 2'b00) $display("FAIL rst_pulses: got %b want 00", {rd_valid, err}); else n_pass++;
        n_total++; if (rd_data !== 32'h0) $display("FAIL rst_rd_data: got %h want 0", rd_data); else n_pass++;
        n_total++; if (ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready); else n_pass++;
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'hA; wr_data = 32'haaaa_aaaa; hready = 1'b1; hresp = 1'b0;
        #1;
        n_total++; if (ready !== 1'b1) $display("FAIL sw_ready: got %b want 1", ready); else n_pass++;
        tick();
        valid = 1'b0;
        n_total++; if (htrans !== 2'b10) $display("FAIL sw_htrans_addr: got %b want 10", htrans); else n_pass++;
        n_total++; if (haddr !== 32'hA) $display("FAIL sw_haddr: got %h want 0000000a", haddr); else n_pass++;
        n_total++; if (hwrite !== 1'b1) $display("FAIL sw_hwrite: got %b want 1", hwrite); else n_pass++;
        tick();
        n_total++; if (htrans !== 2'b00) $display("FAIL sw_htrans_idle: got %b want 00", htrans); else n_pass++;
        n_total++; if (hwdata !== 32'haaaa_aaaa) $display("FAIL sw_hwdata: got %h want aaaaaaaa", hwdata); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL sw_err_dp: got %b want 0", err); else n_pass++;
        tick();
        n_total++; if ({rd_valid, err} !== 2'b00) $display("FAIL sw_pulses: got %b want 00", {rd_valid, err}); else n_pass++;
    endtask

    task automatic test_error_replay();
        valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h40; wr_data = 32'hdead_beef; hready = 1'b1; hresp = 1'b0;
        tick();
        rd0_wr1 = 1'b0; addr = 32'h44; wr_data = 32'h0;
        tick();
        valid = 1'b0; hready = 1'b0; hresp = 1'b1;
        n_total++; if (htrans !== 2'b10 || haddr !== 32'h44) $display("FAIL er_addr44: got %b/%h want 10/00000044", htrans, haddr); else n_pass++;
        tick();
        hready = 1'b1; hresp = 1'b1;
        valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h48; wr_data = 32'h48;
        #1;
        n_total++; if (htrans !== 2'b00) $display("FAIL er_htrans_idle: got %b want 00", htrans); else n_pass++;
        n_total++; if (ready !== 1'b0) $display("FAIL er_ready_replay: got %b want 0", ready); else n_pass++;
        n_total++; if (hwdata !== 32'hdead_beef) $display("FAIL er_hwdata40: got %h want deadbeef", hwdata); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL er_err_early: got %b want 0", err); else n_pass++;
        tick();
        hresp = 1'b0;
        #1;
        n_total++; if (err !== 1'b1 || rd_valid !== 1'b0) $display("FAIL er_err_pulse: got err=%b rdv=%b want 1/0", err, rd_valid); else n_pass++;
        n_total++; if (htrans !== 2'b10 || haddr !== 32'h44 || hwrite !== 1'b0) $display("FAIL er_replay: got %b/%h/%b want 10/00000044/0", htrans, haddr, hwrite); else n_pass++;
        n_total++; if (ready !== 1'b1) $display("FAIL er_ready_after: got %b want 1", ready); else n_pass++;
        tick();
        valid = 1'b0; hrdata = 32'h1234_5678;
        n_total++; if (err !== 1'b0) $display("FAIL er_err_once: got %b want 0", err); else n_pass++;
        n_total++; if (htrans !== 2'b10 || haddr !== 32'h48) $display("FAIL er_addr48: got %b/%h want 10/00000048", htrans, haddr); else n_pass++;
        tick();
        hrdata = 32'h0;
        n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h1234_5678) $display("FAIL er_rd44: got %b/%h want 1/12345678", rd_valid, rd_data); else n_pass++;
        n_total++; if (hwdata !== 32'h48) $display("FAIL er_hwdata48: got %h want 00000048", hwdata); else n_pass++;
        tick();
        n_total++; if ({rd_valid, err, htrans} !== 4'b0000) $display("FAIL er_quiet: got %b want 0000", {rd_valid, err, htrans}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        valid = 1'b1; rd0_wr1 = 1'b0; addr = 32'h50; hready = 1'b1; hresp = 1'b0;
        tick();
        valid = 1'b0;
        tick();
        hrdata = 32'h5050_5050; rstn = 1'b0;
        tick();
        n_total++; if (htrans !== 2'b00) $display("FAIL rm_htrans: got %b want 00", htrans); else n_pass++;
        n_total++; if (hwdata !== 32'h0) $display("FAIL rm_hwdata: got %h want 0", hwdata); else n_pass++;
        n_total++; if ({rd_valid, err} !== 2'b00) $display("FAIL rm_pulses: got %b want 00", {rd_valid, err}); else n_pass++;
        rstn = 1'b1;
        tick();
        n_total++; if ({rd_valid, err} !== 2'b00) $display("FAIL rm_pulses2: got %b want 00", {rd_valid, err}); else n_pass++;
        valid = 1'b1; rd0_wr1 = 1'b1; addr = 32'h54; wr_data = 32'h54;
        tick();
        valid = 1'b0;
        n_total++; if (htrans !== 2'b10 || haddr !== 32'h54 || hwrite !== 1'b1) $display("FAIL rm_addr54: got %b/%h/%b want 10/00000054/1", htrans, haddr, hwrite); else n_pass++;
        tick();
        n_total++; if (hwdata !== 32'h54) $display("FAIL rm_hwdata54: got %h want 00000054", hwdata); else n_pass++;
        tick();
        n_total++; if ({rd_valid, err} !== 2'b00) $display("FAIL rm_done: got %b want 00", {rd_valid, err}); else n_pass++;
    endtask

    task automatic test_idle();
        valid = 1'b0; hready = 1'b1; hresp = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_total++; if (htrans !== 2'b00) $display("FAIL idle_htrans[%0d]: got %b want 00", i, htrans); else n_pass++;
            n_total++;
            if ({hsize, hburst, hprot, hmastlock} !== 11'b010_000_0011_0)
                $display("FAIL idle_consts[%0d]: got %b want 01000000110", i, {hsize, hburst, hprot, hmastlock});
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] sl_mem  [64];
        logic [31:0] ref_mem [64];
        req_t        acc_q[$];
        req_t        wr_q[$];
        logic [31:0] exp_rd[$];
        req_t        req, front;
        logic        req_pend, sl_act, sl_w, sl_err2, drv_ready, cap_act, cap_w;
        logic [31:0] sl_a, cap_a, exp_d;
        int          sl_wait, pulse_flag, pulse_next;

        for (int i = 0; i < 64; i++) begin
            sl_mem[i]  = 32'hC0DE_0000 | i;
            ref_mem[i] = 32'hC0DE_0000 | i;
        end
        req = '0; req_pend = 1'b0; sl_act = 1'b0; sl_w = 1'b0; sl_err2 = 1'b0;
        sl_a = '0; cap_a = '0; cap_w = 1'b0; sl_wait = 0; pulse_flag = 0;

        for (int cyc = 0; cyc < 2400; cyc++) begin
            n_total++;
            if (rd_valid !== (pulse_flag == 1) || err !== (pulse_flag == 2))
                $display("FAIL rnd_pulse@%0d: got rdv=%b err=%b want kind %0d", cyc, rd_valid, err, pulse_flag);
            else n_pass++;
            if (rd_valid === 1'b1 && pulse_flag == 1) begin
                n_total++;
                if (exp_rd.size() == 0) $display("FAIL rnd_rd_data@%0d: got %h want none", cyc, rd_data);
                else begin
                    exp_d = exp_rd.pop_front();
                    if (rd_data !== exp_d) $display("FAIL rnd_rd_data@%0d: got %h want %h", cyc, rd_data, exp_d);
                    else n_pass++;
                end
            end

            pulse_next = 0; drv_ready = 1'b1; hresp = 1'b0; hrdata = $urandom;
            if (sl_act) begin
                if (is_err(sl_a)) begin
                    hresp = 1'b1;
                    if (!sl_err2) drv_ready = 1'b0;
                    else pulse_next = 2;
                end else if (sl_wait > 0) begin
                    drv_ready = 1'b0;
                end else if (!sl_w) begin
                    hrdata = sl_mem[sl_a[7:2]];
                    pulse_next = 1;
                end
                if (drv_ready && sl_w) begin
                    n_total++;
                    if (wr_q.size() == 0) $display("FAIL rnd_hwdata@%0d: got %h want none", cyc, hwdata);
                    else begin
                        front = wr_q.pop_front();
                        if (front.a !== sl_a || hwdata !== front.d)
                            $display("FAIL rnd_hwdata@%0d: got %h@%h want %h@%h", cyc, hwdata, sl_a, front.d, front.a);
                        else n_pass++;
                    end
                    if (!is_err(sl_a)) sl_mem[sl_a[7:2]] = hwdata;
                end
            end
            hready = drv_ready;

            if (!req_pend && cyc < 2000 && $urandom_range(0, 3) != 0) begin
                req.w = 1'($urandom_range(0, 1));
                req.a = $urandom_range(0, 63) << 2;
                req.d = $urandom;
                req_pend = 1'b1;
            end
            valid = req_pend; rd0_wr1 = req.w; addr = req.a; wr_data = req.d;
            #1;

            n_total++;
            if (htrans !== 2'b00 && htrans !== 2'b10) $display("FAIL rnd_htrans@%0d: got %b want 00 or 10", cyc, htrans);
            else n_pass++;

            cap_act = 1'b0;
            if (drv_ready && htrans === 2'b10) begin
                cap_act = 1'b1; cap_a = haddr; cap_w = hwrite;
                n_total++;
                if (acc_q.size() == 0) $display("FAIL rnd_addr@%0d: got %h want none", cyc, haddr);
                else begin
                    front = acc_q.pop_front();
                    if (front.a !== haddr || front.w !== hwrite)
                        $display("FAIL rnd_addr@%0d: got %h/%b want %h/%b", cyc, haddr, hwrite, front.a, front.w);
                    else n_pass++;
                end
            end

            if (valid && ready === 1'b1) begin
                acc_q.push_back(req);
                if (req.w) begin
                    wr_q.push_back(req);
                    if (!is_err(req.a)) ref_mem[req.a[7:2]] = req.d;
                end else if (!is_err(req.a)) begin
                    exp_rd.push_back(ref_mem[req.a[7:2]]);
                end
                req_pend = 1'b0;
            end

            @(posedge clk);
            if (drv_ready) begin
                sl_act = cap_act; sl_a = cap_a; sl_w = cap_w; sl_err2 = 1'b0;
                sl_wait = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            end else if (sl_act && is_err(sl_a)) begin
                sl_err2 = 1'b1;
            end else if (sl_wait > 0) begin
                sl_wait--;
            end
            pulse_flag = pulse_next;
            @(negedge clk);
        end
        valid = 1'b0; hready = 1'b1; hresp = 1'b0;

        n_total++;
        if (acc_q.size() != 0 || wr_q.size() != 0 || exp_rd.size() != 0 || req_pend)
            $display("FAIL rnd_drain: got addr=%0d wr=%0d rd=%0d pend=%b want all 0",
                     acc_q.size(), wr_q.size(), exp_rd.size(), req_pend);
        else n_pass++;
    endtask

    initial begin
        rstn = 1'b0; valid = 1'b0; rd0_wr1 = 1'b0; addr = '0; wr_data = '0;
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        @(negedge clk);
        test_reset();
        test_single_write();
        test_error_replay();
        test_reset_mid();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
